// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, default line settings and
// the oversample tick divider calculation used by both link directions.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  localparam int DEFAULT_CLK_FREQ  = 50_000_000;
  localparam int DEFAULT_BAUD_RATE = 115200;
  localparam int DATA_BITS         = 8;

  // Clocks per oversample tick, floored; never below one clock.
  function automatic int calc_tick_div(input int clk_freq, input int baud_rate,
                                       input int oversample);
    int div;
    div = clk_freq / (baud_rate * oversample);
    if (div < 1) begin
      div = 1;
    end else begin
      div = div;
    end
    return div;
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Byte-side and line-side signals of the UART receiver. The master drives the
// serial line and consumes bytes; the slave is the receiver itself.
interface uart_rx_if;
  import uart_pkg::*;

  logic                 rx;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_busy;
  logic                 rx_frame_err;

  modport master (
    output rx,
    input  rx_data,
    input  rx_valid,
    input  rx_busy,
    input  rx_frame_err
  );

  modport slave (
    input  rx,
    output rx_data,
    output rx_valid,
    output rx_busy,
    output rx_frame_err
  );

endinterface

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for a single asynchronous bit; both flops load
// RST_VAL on reset so an idle-high line shows no edge coming out of reset.
module uart_sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_q;

  // Metastability chain
  always_ff @(posedge clk) begin
    if (rst) begin
      r_meta <= RST_VAL;
      r_q    <= RST_VAL;
    end else begin
      r_meta <= i_d;
      r_q    <= r_meta;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with OVERSAMPLE-times oversampling. Emits each good byte
// with a one-cycle valid strobe and flags a low stop bit as a frame error.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = DEFAULT_CLK_FREQ,
  parameter int BAUD_RATE  = DEFAULT_BAUD_RATE,
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       rst,
  uart_rx_if.slave   if_rx
);

  localparam int TICK_DIV = calc_tick_div(CLK_FREQ, BAUD_RATE, OVERSAMPLE);
  localparam int TICK_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SMP_W    = $clog2(OVERSAMPLE);

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
  localparam logic [SMP_W-1:0]  SMP_MID   = SMP_W'(OVERSAMPLE / 2 - 1);
  localparam logic [SMP_W-1:0]  SMP_LAST  = SMP_W'(OVERSAMPLE - 1);
  localparam logic [2:0]        BIT_LAST  = 3'(DATA_BITS - 1);

  logic                 w_rx_s;
  logic                 w_fall;
  logic                 w_tick;

  logic                 r_rx_prev;
  logic [TICK_W-1:0]    r_tick_cnt;
  logic [SMP_W-1:0]     r_smp_cnt;
  logic [2:0]           r_bit_cnt;
  logic [DATA_BITS-1:0] r_shift;
  state_t               r_state;

  logic [DATA_BITS-1:0] r_data;
  logic                 r_valid;
  logic                 r_frame_err;
  logic                 r_busy;

  state_t               w_state_nxt;
  logic                 w_start_det;
  logic                 w_smp_clr;
  logic                 w_shift_en;
  logic                 w_valid_set;
  logic                 w_ferr_set;

  uart_sync2 #(.RST_VAL(1'b1)) u_sync (
    .clk (clk),
    .rst (rst),
    .i_d (if_rx.rx),
    .o_q (w_rx_s)
  );

  assign w_fall = r_rx_prev & ~w_rx_s;
  assign w_tick = (r_tick_cnt == TICK_LAST);

  // Edge register tracks the line in every state, so a line stuck low after
  // a frame error cannot produce a new start edge until it has gone high.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_prev <= 1'b1;
    end else begin
      r_rx_prev <= w_rx_s;
    end
  end

  // Oversample tick divider, re-phased on each detected start edge
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tick_cnt <= '0;
    end else if (w_start_det || w_tick) begin
      r_tick_cnt <= '0;
    end else begin
      r_tick_cnt <= r_tick_cnt + TICK_W'(1);
    end
  end

  // Next-state and datapath control
  always_comb begin
    w_state_nxt = r_state;
    w_start_det = 1'b0;
    w_smp_clr   = 1'b0;
    w_shift_en  = 1'b0;
    w_valid_set = 1'b0;
    w_ferr_set  = 1'b0;

    case (r_state)
      IDLE: begin
        if (w_fall) begin
          w_state_nxt = START;
          w_start_det = 1'b1;
          w_smp_clr   = 1'b1;
        end else begin
          w_state_nxt = IDLE;
        end
      end

      // A line that is high again at mid start bit was only a glitch
      START: begin
        if (w_tick && (r_smp_cnt == SMP_MID)) begin
          w_smp_clr = 1'b1;
          if (w_rx_s) begin
            w_state_nxt = IDLE;
          end else begin
            w_state_nxt = DATA;
          end
        end else begin
          w_state_nxt = START;
        end
      end

      DATA: begin
        if (w_tick && (r_smp_cnt == SMP_LAST)) begin
          w_shift_en = 1'b1;
          w_smp_clr  = 1'b1;
          if (r_bit_cnt == BIT_LAST) begin
            w_state_nxt = STOP;
          end else begin
            w_state_nxt = DATA;
          end
        end else begin
          w_state_nxt = DATA;
        end
      end

      STOP: begin
        if (w_tick && (r_smp_cnt == SMP_LAST)) begin
          w_state_nxt = IDLE;
          w_smp_clr   = 1'b1;
          if (w_rx_s) begin
            w_valid_set = 1'b1;
          end else begin
            w_ferr_set  = 1'b1;
          end
        end else begin
          w_state_nxt = STOP;
        end
      end

      default: begin
        w_state_nxt = IDLE;
        w_smp_clr   = 1'b1;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Sample counter: restarts on every state entry, parked at zero in IDLE
  always_ff @(posedge clk) begin
    if (rst) begin
      r_smp_cnt <= '0;
    end else if (w_smp_clr) begin
      r_smp_cnt <= '0;
    end else if (w_tick && (r_state != IDLE)) begin
      r_smp_cnt <= r_smp_cnt + SMP_W'(1);
    end else begin
      r_smp_cnt <= r_smp_cnt;
    end
  end

  // Bit counter and LSB-first shift register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_bit_cnt <= 3'd0;
      r_shift   <= '0;
    end else if (w_start_det) begin
      r_bit_cnt <= 3'd0;
      r_shift   <= r_shift;
    end else if (w_shift_en) begin
      r_bit_cnt <= r_bit_cnt + 3'd1;
      r_shift   <= {w_rx_s, r_shift[DATA_BITS-1:1]};
    end else begin
      r_bit_cnt <= r_bit_cnt;
      r_shift   <= r_shift;
    end
  end

  // Registered outputs; busy follows the next state so it drops with the strobe
  always_ff @(posedge clk) begin
    if (rst) begin
      r_data      <= '0;
      r_valid     <= 1'b0;
      r_frame_err <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_valid     <= w_valid_set;
      r_frame_err <= w_ferr_set;
      r_busy      <= (w_state_nxt != IDLE);
      if (w_valid_set) begin
        r_data <= r_shift;
      end else begin
        r_data <= r_data;
      end
    end
  end

  assign if_rx.rx_data      = r_data;
  assign if_rx.rx_valid     = r_valid;
  assign if_rx.rx_frame_err = r_frame_err;
  assign if_rx.rx_busy      = r_busy;

endmodule
